// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions: opcodes, instruction classes and the memory
// responder's request/state types.
package mips32_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        INSTR_R,
        INSTR_I,
        INSTR_J
    } instr_type_e;

    function automatic instr_type_e instr_type(input logic [5:0] opcode);
        case (opcode)
            OP_RTYPE:    return INSTR_R;
            OP_J, OP_JAL: return INSTR_J;
            default:     return INSTR_I;
        endcase
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_rsp_state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mips32_word_ram.sv
// DEPTH x 32 word storage: one synchronous write port, one combinational
// read port. Contents survive reset.
module mips32_word_ram #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = 10
) (
    input  logic              clk1,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [31:0]       wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [31:0]       rd_data
);

    logic [31:0] mem [DEPTH];

    // NOTE: storage arrays take no reset; a reset branch here would turn the
    // array into flops and break the retain-across-reset behaviour.
    always_ff @(posedge clk1) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/mips32_mem_responder.sv
// Word-addressed memory responder for the MIPS32 core with programmable wait
// states and a side-band loader port. ADDR_W may be at most 32.
module mips32_mem_responder
    import mips32_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    output logic              busy,
    output logic [CNT_W-1:0]  access_cnt
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    mem_rsp_state_e   state;
    mem_rsp_state_e   state_next;
    mem_req_t         req_in;
    logic [3:0]       wait_cnt;
    logic             lat_we;
    logic             lat_err;
    logic [IDX_W-1:0] lat_idx;

    logic             load_hs;
    logic             req_hs;
    logic             req_err;
    logic             load_in_range;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [31:0]      wr_data;
    logic [31:0]      rd_data;

    assign req_in = '{we: req_we, addr: 32'(req_addr), wdata: req_wdata};

    // Loader has priority: the core only handshakes in IDLE with no load pending.
    assign load_hs       = (state == IDLE) && load_valid;
    assign req_hs        = (state == IDLE) && req_valid && !load_valid;
    assign req_err       = req_in.addr >= 32'(DEPTH);
    assign load_in_range = load_addr < ADDR_W'(DEPTH);

    assign wr_en   = (load_hs && load_in_range) || (req_hs && req_in.we && !req_err);
    assign wr_idx  = load_hs ? load_addr[IDX_W-1:0] : req_in.addr[IDX_W-1:0];
    assign wr_data = load_hs ? load_data : req_in.wdata;

    assign busy = (state != IDLE);

    mips32_word_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk1    (clk1),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .rd_idx  (lat_idx),
        .rd_data (rd_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        load_ready = 1'b0;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
                req_ready  = !load_valid;
                if (req_valid && !load_valid) begin
                    state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_valid && rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The first RESP cycle loads the response; later RESP cycles hold it
    // until the core takes it.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt   <= 4'd0;
            lat_we     <= 1'b0;
            lat_err    <= 1'b0;
            lat_idx    <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'd0;
            rsp_err    <= 1'b0;
            access_cnt <= '0;
        end else begin
            if (req_hs) begin
                lat_we   <= req_in.we;
                lat_err  <= req_err;
                lat_idx  <= req_in.addr[IDX_W-1:0];
                wait_cnt <= 4'(WAIT_CYCLES - 1);
            end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            if (state == RESP) begin
                if (!rsp_valid) begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= lat_err;
                    rsp_rdata <= (!lat_we && !lat_err) ? rd_data : 32'd0;
                end else if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    rsp_rdata <= 32'd0;
                    rsp_err   <= 1'b0;
                    if (access_cnt != {CNT_W{1'b1}}) begin
                        access_cnt <= access_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule
